// File: rtl/mult_div_pkg.sv
// Shared types and helpers for the sequential divider.
// State encoding and counter sizing.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One restoring division step: shift in a bit, trial-subtract.
// Pure combinational; the caller holds the partial remainder.
module mult_div_step #(
  parameter int width_d = 8
) (
  input  logic [width_d:0]   rem_in,
  input  logic               bit_in,
  input  logic [width_d-1:0] dvs,
  output logic [width_d:0]   rem_out,
  output logic               q_bit
);

  logic [width_d+1:0] wide;
  logic [width_d+1:0] diff;

  assign wide = {rem_in, bit_in};
  assign diff = wide - {2'b00, dvs};

  // Sign of the widened difference decides keep vs restore.
  assign q_bit   = ~diff[width_d+1];
  assign rem_out = q_bit ? diff[width_d:0] : wide[width_d:0];

endmodule

// File: rtl/mult_div_seq.sv
// Iterative restoring divider with per-operand signedness.
// Fixed latency of width_n+2 enabled edges, including divide by zero.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int width_n = 8,
  parameter int width_d = 8
) (
  input  logic               clock0,
  input  logic               aclr_n,
  input  logic               ena0,
  input  logic               start,
  input  logic [width_n-1:0] numer,
  input  logic [width_d-1:0] denom,
  input  logic               signa,
  input  logic               signb,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [width_n-1:0] quotient,
  output logic [width_d-1:0] remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int cw = clog2(width_n);
  localparam logic [cw-1:0] cnt_init = cw'(width_n - 1);
  localparam logic [width_n-1:0] msb_only =
    {1'b1, {(width_n-1){1'b0}}};

  state_t state;
  logic [cw-1:0] cnt;

  logic [width_n-1:0] na;
  logic [width_d-1:0] da;
  logic [width_d-1:0] rlo;
  logic [width_d:0]   rm;
  logic sa, sb, sgn;
  logic neg_q, neg_r, dz;

  logic neg_n, neg_d;
  logic [width_d:0] rm_nxt;
  logic q_bit;

  assign neg_n = sa & na[width_n-1];
  assign neg_d = sb & da[width_d-1];

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  mult_div_step #(
    .width_d (width_d)
  ) u_step (
    .rem_in  (rm),
    .bit_in  (na[width_n-1]),
    .dvs     (da),
    .rem_out (rm_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clock0 or negedge aclr_n) begin
    if (!aclr_n) begin
      state       <= IDLE;
      cnt         <= '0;
      na          <= '0;
      da          <= '0;
      rlo         <= '0;
      rm          <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      sgn         <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (ena0) begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            na    <= numer;
            da    <= denom;
            sa    <= signa;
            sb    <= signb;
            state <= LOAD;
          end
        end
        LOAD: begin
          na    <= neg_n ? -na : na;
          da    <= neg_d ? -da : da;
          neg_q <= neg_n ^ neg_d;
          neg_r <= neg_n;
          dz    <= (da == '0);
          rlo   <= na[width_d-1:0];
          sgn   <= sa | sb;
          rm    <= '0;
          cnt   <= cnt_init;
          state <= ITER;
        end
        ITER: begin
          // na doubles as the quotient shift register.
          na <= {na[width_n-2:0], q_bit};
          rm <= rm_nxt;
          if (cnt == '0) state <= FIX;
          else cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (dz) begin
            quotient    <= '1;
            remainder   <= rlo;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            quotient    <= neg_q ? -na : na;
            remainder   <= neg_r ? -rm[width_d-1:0]
                                 : rm[width_d-1:0];
            div_by_zero <= 1'b0;
            overflow    <= sgn & (neg_q ? (na > msb_only)
                                        : (na >= msb_only));
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
- Iterative restoring divider; the inverse datapath companion to the multiply-add blocks in the arithmetic library.
- Accepts a numerator/denominator pair under a start/ready handshake and produces a quotient and remainder after a fixed latency.
- Signedness is selected per operand with signa/signb, the same way as for the multiply-add family.
- Used by elaborated designs that infer "/" or "%" on non-constant operands.

Parameters:
- width_n, 8, numerator and quotient width (≥2)
- width_d, 8, denominator and remainder width (≥2, ≤ width_n)

Ports:
- clock0  in  1  sole clock, rising edge
- aclr_n  in  1  asynchronous active-low reset
- ena0  in  1  clock enable; when 0 every register holds and start is ignored
- start  in  1  request; accepted only on an edge where ready=1 and ena0=1
- numer  in  width_n  numerator, sampled on the accept edge
- denom  in  width_d  denominator, sampled on the accept edge
- signa  in  1  1 = numer is two's complement; sampled on the accept edge
- signb  in  1  1 = denom is two's complement; sampled on the accept edge
- ready  out  1  high in IDLE
- busy  out  1  high in LOAD, ITER and FIX
- done  out  1  one-cycle pulse when results update
- quotient  out  width_n  result quotient, held until the next done
- remainder  out  width_d  result remainder, held until the next done
- div_by_zero  out  1  denom was 0; valid with done, held
- overflow  out  1  quotient not representable; valid with done, held

Behaviour:
- Reset (aclr_n=0, async): state=IDLE, ready=1, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, counter=0.
- States:
  - IDLE -(accepted start)-> LOAD
  - LOAD -> ITER, with counter=width_n-1
  - ITER -> ITER while counter≠0, decrementing each cycle; counter=0 -> FIX
  - FIX -> IDLE
- LOAD:
  - Register the magnitudes |numer| and |denom|, using signa/signb for interpretation.
  - Register neg_q = (numer negative) XOR (denom negative), neg_r = numer negative, and dz = (denom==0).
- ITER: one restoring step per cycle, MSB first.
  - Partial remainder width is width_d+1.
  - Shift in the next numerator bit, trial-subtract |denom|; the quotient bit is 1 if the result is non-negative, and the partial remainder is restored otherwise.
- FIX: apply signs and register the outputs; done=1 on the edge leaving FIX.
  - quotient = low width_n bits of the true two's-complement quotient (truncation toward zero).
  - remainder = neg_r ? -rm : rm.
- Latency: start accepted at edge 0; done is high in the cycle after edge width_n+2; ready returns in that same cycle. This is fixed for all operands, including divide by zero.
- Result signedness: the quotient is signed if signa|signb.
  - overflow=1 if signed and (neg_q and qm > 2^(width_n-1), or !neg_q and qm ≥ 2^(width_n-1)); qm is the magnitude quotient.
  - overflow=0 if unsigned.
- Divide by zero:
  - quotient = all ones, remainder = numer[width_d-1:0], div_by_zero=1, overflow=0.
  - The ITER cycles still elapse.
- start while busy: ignored, no queueing. start coincident with done (the cycle ready rises) is accepted on the following edge.
- ena0=0 mid-operation: the state and counter freeze; done does not pulse while ena0=0. A done pulse pending at an ena0 drop is stretched until the next enabled edge.
- Reset mid-operation: immediate return to the reset values; no done pulse.

Decomposition:
- Package mult_div_pkg: state enum (IDLE, LOAD, ITER, FIX) and a counter-width function clog2(width_n).
- One sub-module, mult_div_step: combinational restoring step.
  - Inputs: partial remainder, next bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
- The top level holds the FSM, the registers and the sign fix-up.

Test Plan:
- Unsigned 100/7 (width 8): start at edge 0 -> done after edge 10; quotient=14, remainder=2, flags 0; ready=0 for cycles 1-10.
- Signed -7/2 (numer=0xF9, denom=0x02, signa=signb=1) -> quotient=0xFD (-3), remainder=0xFF (-1), overflow=0.
- 55/0 unsigned -> quotient=0xFF, remainder=0x37, div_by_zero=1, at the same latency of 10.
- Signed -128/-1 (0x80/0xFF) -> quotient=0x80, remainder=0, overflow=1; unsigned 255 / signed -1 -> quotient=0x01, overflow=1.
- start pulsed at edge 4 while busy -> ignored, one done only.
  - Then hold ena0=0 for 3 cycles mid-ITER -> done delayed by exactly 3 cycles and results unchanged.
- Assert aclr_n low at edge 5 of an operation -> all outputs 0, ready=1 immediately, and no done pulse.
  - A new start afterwards -> correct result (200/3 -> 66 r 2).
